arbitro_param: RTL and testbench

//  N-requester arbiter, registered successor of the 4-input fixed-priority arbiter.

---
 rtl/arbitro_pkg.sv | 13 +
 rtl/arbitro_prio_enc.sv | 38 +++
 rtl/arbitro_param.sv | 124 ++++++++++++
 tb/tb_arbitro_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the parameterised arbiter.
package arbitro_pkg;

   typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

   typedef enum logic {ST_IDLE, ST_BUSY} arb_state_e;

   // Width of a requester index; at least one bit even for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arbitro_prio_enc.sv
// Combinational circular priority search over a masked request vector.
// The search visits every index once, starting at start_idx and moving up
// (wrapping N-1 -> 0) or down (wrapping 0 -> N-1); the first set bit wins.
module arbitro_prio_enc
   import arbitro_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_masked,
   input  logic [idx_w(N)-1:0]  start_idx,
   input  logic                 dir_up,
   output logic                 valid,
   output logic [idx_w(N)-1:0]  idx
);

   localparam int IW = idx_w(N);

   // Position visited at search step k, wrapped into 0..N-1.
   function automatic int wrap_pos(input int s, input int k, input logic up);
      int p;
      p = up ? (s + k) : (s - k + N);
      if (p >= N) p = p - N;
      return p;
   endfunction

   // Scan from the last step back to the first so the earliest hit overrides.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_masked[wrap_pos(int'(start_idx), k, dir_up)]) begin
            valid = 1'b1;
            idx   = IW'(wrap_pos(int'(start_idx), k, dir_up));
         end
      end
   end

endmodule

// File: rtl/arbitro_param.sv
// N-requester registered arbiter. A grant is held until its owner drops req;
// fixed priority (highest index) or round-robin is chosen at each arbitration
// edge, and an optional hold limit forces a hand-over under contention.
module arbitro_param
   import arbitro_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic                  mode_rr,
   output logic [N-1:0]          grant,
   output logic [$clog2(N)-1:0]  grant_num,
   output logic                  available
);

   localparam int IW = idx_w(N);
   // Counter only needs to reach MAX_HOLD-1; with no limit it is a free
   // saturating counter that never triggers anything.
   localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) :
                        ((MAX_HOLD == 1) ? 1 : 8);
   localparam logic [HCW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1)
                                                        : {HCW{1'b1}};
   localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

   arb_state_e      state;
   logic [HCW-1:0]  hold_cnt;
   logic [IW-1:0]   rr_ptr;

   arb_mode_e       mode;
   logic [N-1:0]    owner_mask;
   logic [N-1:0]    req_masked;
   logic            owner_req;
   logic            contended;
   logic            force_rel;
   logic            dir_up;
   logic [IW-1:0]   start_idx;
   logic            enc_valid;
   logic [IW-1:0]   enc_idx;
   logic [IW-1:0]   next_ptr;
   logic [N-1:0]    win_onehot;

   // Owner masking, forced-release detection and search setup for this edge.
   always_comb begin
      mode       = arb_mode_e'(mode_rr);
      owner_mask = (state == ST_BUSY) ? grant : '0;
      owner_req  = |(req & owner_mask);
      req_masked = req & ~owner_mask;
      contended  = |req_masked;
      force_rel  = (MAX_HOLD > 0) && (state == ST_BUSY) &&
                   (hold_cnt == HOLD_SAT) && contended;
      dir_up     = (mode == ARB_RR);
      start_idx  = dir_up ? rr_ptr : LAST_IDX;
      next_ptr   = (enc_idx == LAST_IDX) ? '0 : enc_idx + 1'b1;
      win_onehot = {{(N-1){1'b0}}, 1'b1} << enc_idx;
   end

   arbitro_prio_enc #(
      .N (N)
   ) u_prio_enc (
      .req_masked (req_masked),
      .start_idx  (start_idx),
      .dir_up     (dir_up),
      .valid      (enc_valid),
      .idx        (enc_idx)
   );

   // Arbiter FSM with registered grant outputs, hold counter and rr pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         grant_num <= '0;
         available <= 1'b1;
         hold_cnt  <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               hold_cnt <= '0;
               if (enc_valid) begin
                  state     <= ST_BUSY;
                  grant     <= win_onehot;
                  grant_num <= enc_idx;
                  available <= 1'b0;
                  rr_ptr    <= next_ptr;
               end else begin
                  grant     <= '0;
                  grant_num <= '0;
                  available <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (owner_req && !force_rel) begin
                  // Owner keeps the grant; counter sticks at its ceiling.
                  if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
               end else if (enc_valid) begin
                  // Release or forced hand-over straight to the next winner.
                  grant     <= win_onehot;
                  grant_num <= enc_idx;
                  hold_cnt  <= '0;
                  rr_ptr    <= next_ptr;
               end else begin
                  state     <= ST_IDLE;
                  grant     <= '0;
                  grant_num <= '0;
                  available <= 1'b1;
                  hold_cnt  <= '0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               grant     <= '0;
               grant_num <= '0;
               available <= 1'b1;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arbitro_param.sv
// Bench for arbitro_param: four builds (N=4/MAX_HOLD=4, N=4/MAX_HOLD=1,
// N=2/unlimited, N=7/MAX_HOLD=3) share clock, reset, mode and request bits.
// A per-build reference model tracks owner, hold count and rr pointer as
// plain integers and predicts every output each cycle.
module tb_arbitro_param;

   localparam int NI = 4;

   logic       clk;
   logic       rst;
   logic       mode_rr;
   logic [6:0] req_all;

   logic [3:0] g_a, g_b;
   logic [1:0] gn_a, gn_b;
   logic       av_a, av_b;
   logic [1:0] g_c;
   logic [0:0] gn_c;
   logic       av_c;
   logic [6:0] g_d;
   logic [2:0] gn_d;
   logic       av_d;

   arbitro_param #(.N(4), .MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst), .req(req_all[3:0]), .mode_rr(mode_rr),
      .grant(g_a), .grant_num(gn_a), .available(av_a));

   arbitro_param #(.N(4), .MAX_HOLD(1)) dut_h1 (
      .clk(clk), .rst(rst), .req(req_all[3:0]), .mode_rr(mode_rr),
      .grant(g_b), .grant_num(gn_b), .available(av_b));

   arbitro_param #(.N(2), .MAX_HOLD(0)) dut_n2 (
      .clk(clk), .rst(rst), .req(req_all[1:0]), .mode_rr(mode_rr),
      .grant(g_c), .grant_num(gn_c), .available(av_c));

   arbitro_param #(.N(7), .MAX_HOLD(3)) dut_n7 (
      .clk(clk), .rst(rst), .req(req_all[6:0]), .mode_rr(mode_rr),
      .grant(g_d), .grant_num(gn_d), .available(av_d));

   logic [6:0] g_obs  [NI];
   logic [2:0] n_obs  [NI];
   logic       a_obs  [NI];

   always_comb begin
      g_obs[0] = {3'b0, g_a};  n_obs[0] = {1'b0, gn_a}; a_obs[0] = av_a;
      g_obs[1] = {3'b0, g_b};  n_obs[1] = {1'b0, gn_b}; a_obs[1] = av_b;
      g_obs[2] = {5'b0, g_c};  n_obs[2] = {2'b0, gn_c}; a_obs[2] = av_c;
      g_obs[3] = g_d;          n_obs[3] = gn_d;         a_obs[3] = av_d;
   end

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_n  [NI] = '{4, 4, 2, 7};
   int m_mh [NI] = '{4, 1, 0, 3};
   int m_own[NI];
   int m_hold[NI];
   int m_ptr[NI];

   function automatic void model_step(input int k, input logic [6:0] r,
                                      input logic m, input logic rs);
      int n, mh, w;
      logic [6:0] cand;
      n  = m_n[k];
      mh = m_mh[k];
      if (rs) begin
         m_own[k] = -1; m_hold[k] = 0; m_ptr[k] = 0;
         return;
      end
      cand = r & ((7'(1) << n) - 7'(1));
      if (m_own[k] >= 0) begin
         cand[m_own[k]] = 1'b0;
         if (r[m_own[k]] && !(mh > 0 && m_hold[k] == mh - 1 && cand != 0)) begin
            if (mh == 0 || m_hold[k] < mh - 1) m_hold[k] = m_hold[k] + 1;
            return;
         end
      end
      w = -1;
      for (int i = 0; i < n; i++) begin
         int p;
         p = m ? ((m_ptr[k] + i) % n) : (n - 1 - i);
         if (w < 0 && cand[p]) w = p;
      end
      m_hold[k] = 0;
      if (w < 0) begin
         m_own[k] = -1;
      end else begin
         m_own[k] = w;
         m_ptr[k] = (w + 1) % n;
      end
   endfunction

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [6:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // Apply inputs, advance one edge, update the model, then compare
   // all builds one time unit after the edge.
   task automatic step(input logic [6:0] r, input logic m, input logic rs);
      logic [6:0] eg;
      logic [6:0] rk;
      req_all = r;
      mode_rr = m;
      rst     = rs;
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
         model_step(k, r, m, rs);
         exp_q.push_back((m_own[k] >= 0) ? (7'(1) << m_own[k]) : 7'd0);
      end
      #1;
      for (int k = 0; k < NI; k++) begin
         eg = exp_q.pop_front();
         rk = r & ((7'(1) << m_n[k]) - 7'(1));
         check($sformatf("grant[%0d]", k), 32'(g_obs[k]), 32'(eg));
         check($sformatf("grant_num[%0d]", k), 32'(n_obs[k]),
               (m_own[k] >= 0) ? 32'(m_own[k]) : 32'd0);
         check($sformatf("available[%0d]", k), 32'(a_obs[k]),
               32'(m_own[k] < 0));
         check($sformatf("onehot0[%0d]", k), 32'($onehot0(g_obs[k])), 32'd1);
         check($sformatf("gnt_in_req[%0d]", k), 32'(g_obs[k] & ~rk), 32'd0);
         if (!a_obs[k])
            check($sformatf("gnt_at_num[%0d]", k), 32'(g_obs[k][n_obs[k]]), 32'd1);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0] r;
      logic       m;
      rst = 1'b1; req_all = '0; mode_rr = 1'b0;
      for (int k = 0; k < NI; k++) begin
         m_own[k] = -1; m_hold[k] = 0; m_ptr[k] = 0;
      end

      // 1: reset with all requests up, then fixed-priority winner is index 3
      repeat (2) begin
         step(7'b0001111, 1'b0, 1'b1);
         check("t1_rst_grant", 32'(g_a), 32'd0);
         check("t1_rst_num", 32'(gn_a), 32'd0);
         check("t1_rst_avail", 32'(av_a), 32'd1);
      end
      step(7'b0001111, 1'b0, 1'b0);
      check("t1_grant", 32'(g_a), 32'b1000);
      check("t1_num", 32'(gn_a), 32'd3);

      // 2: owner 3 drops, 2 wins, then same-edge hand-over to 0
      step(7'b0000101, 1'b0, 1'b0);
      check("t2_grant_a", 32'(g_a), 32'b0100);
      step(7'b0000101, 1'b0, 1'b0);
      check("t2_grant_b", 32'(g_a), 32'b0100);
      step(7'b0000001, 1'b0, 1'b0);
      check("t2_handover", 32'(g_a), 32'b0001);
      check("t2_no_bubble", 32'(av_a), 32'd0);

      // 3: round-robin rotation with a one-cycle hold limit
      step(7'b0000000, 1'b1, 1'b1);
      step(7'b0001111, 1'b1, 1'b0);
      check("t3_g0", 32'(g_b), 32'b0001);
      step(7'b0001111, 1'b1, 1'b0);
      check("t3_g1", 32'(g_b), 32'b0010);
      step(7'b0001111, 1'b1, 1'b0);
      check("t3_g2", 32'(g_b), 32'b0100);
      step(7'b0001111, 1'b1, 1'b0);
      check("t3_g3", 32'(g_b), 32'b1000);
      check("t3_ptr_wrap", 32'(dut_h1.rr_ptr), 32'd0);
      step(7'b0001111, 1'b1, 1'b0);
      check("t3_g4", 32'(g_b), 32'b0001);

      // 4: lone requester saturates the hold counter, then forced hand-over
      step(7'b0000000, 1'b0, 1'b1);
      repeat (10) step(7'b0001000, 1'b0, 1'b0);
      check("t4_grant", 32'(g_a), 32'b1000);
      check("t4_hold_sat", 32'(dut.hold_cnt), 32'd3);
      step(7'b0001010, 1'b0, 1'b0);
      check("t4_forced", 32'(g_a), 32'b0010);

      // 5: mode toggles mid-grant leave the owner alone; then it releases
      step(7'b0000010, 1'b1, 1'b0);
      check("t5_mode_hold_a", 32'(g_a), 32'b0010);
      step(7'b0000010, 1'b0, 1'b0);
      check("t5_mode_hold_b", 32'(g_a), 32'b0010);
      step(7'b0000000, 1'b0, 1'b0);
      check("t5_rel_avail", 32'(av_a), 32'd1);
      check("t5_rel_grant", 32'(g_a), 32'd0);
      check("t5_rel_num", 32'(gn_a), 32'd0);

      // 6: reset mid-grant drops it on that edge
      step(7'b0000100, 1'b0, 1'b0);
      check("t6_pre", 32'(g_a), 32'b0100);
      step(7'b0000100, 1'b0, 1'b1);
      check("t6_rst_grant", 32'(g_a), 32'd0);
      check("t6_rst_avail", 32'(av_a), 32'd1);

      // Random run: sticky request bits, occasional mode flips and resets
      r = 7'($urandom);
      m = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < 7; b++)
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         if ($urandom_range(0, 15) == 0) m = ~m;
         step(r, m, ($urandom_range(0, 199) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
